// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the reset release sequencer.
// Sizing helpers keep port and counter widths consistent across files.
package reset_seq_pkg;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_NUM_DOMAINS = 3;
   localparam int DEF_GAP_CYCLES  = 16;
   localparam int DEF_ACK_TIMEOUT = 1023;

   typedef enum logic [2:0] {
      HOLD,
      RELEASE,
      WAIT_ACK,
      GAP,
      RUN,
      FAULT
   } seq_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wide enough to hold the larger of the two load values without wrapping.
   function automatic int cnt_width(input int gap, input int ack);
      return $clog2(((gap > ack) ? gap : ack) + 1);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts immediately, releases after STAGES clock edges.
// Its output is the only reset seen by the sequencer logic.
module reset_sync #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   output logic reset_sync_n
);

   logic [STAGES-1:0] sync_q;

   // NOTE: the asynchronous clear makes assertion immediate; the shift chain
   // only delays the release, so downstream flops never leave reset near an edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], 1'b1};
      end
   end

   assign reset_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/reset_release_seq.sv
// Releases NUM_DOMAINS resets one at a time, waiting for each acknowledge,
// with a single shared down-counter timing both the gaps and the ack timeout.
module reset_release_seq
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 io_terminate,
   input  logic                                 io_soft_reset_req,
   input  logic [NUM_DOMAINS-1:0]               io_domain_ready,
   output logic [NUM_DOMAINS-1:0]               io_domain_reset,
   output logic                                 io_done,
   output logic                                 io_fault,
   output logic [idx_width(NUM_DOMAINS)-1:0]    io_fault_domain
);

   localparam int IDX_W = idx_width(NUM_DOMAINS);
   localparam int CNT_W = cnt_width(GAP_CYCLES, ACK_TIMEOUT);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             rst_sync_n;
   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             terminate_q;
   logic             terminate_rise;

   reset_sync #(
      .STAGES       (SYNC_STAGES)
   ) u_reset_sync (
      .clock        (clock),
      .reset        (reset),
      .reset_sync_n (rst_sync_n)
   );

   assign terminate_rise = io_terminate & ~terminate_q;

   // NOTE: all state and outputs use non-blocking assignments so every branch
   // below reads the pre-edge values, regardless of statement order.
   always_ff @(posedge clock or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state           <= HOLD;
         cnt             <= '0;
         idx             <= '0;
         terminate_q     <= 1'b0;
         io_domain_reset <= '1;
         io_done         <= 1'b0;
         io_fault        <= 1'b0;
         io_fault_domain <= '0;
      end else begin
         terminate_q <= io_terminate;

         case (state)
            // A zero count marks the first HOLD cycle, so entry from reset,
            // RUN and FAULT all share the same GAP_CYCLES-long hold.
            HOLD: begin
               idx <= '0;
               if (cnt == CNT_ONE || (cnt == '0 && GAP_CYCLES == 1)) begin
                  cnt   <= '0;
                  state <= RELEASE;
               end else if (cnt == '0) begin
                  cnt <= HOLD_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            RELEASE: begin
               io_domain_reset[idx] <= 1'b0;
               cnt                  <= ACK_LOAD;
               state                <= WAIT_ACK;
            end

            // Ready on the final allowed cycle wins over the timeout.
            WAIT_ACK: begin
               if (io_domain_ready[idx]) begin
                  cnt   <= GAP_LOAD;
                  state <= GAP;
               end else if (cnt == CNT_ONE) begin
                  cnt             <= '0;
                  io_domain_reset <= '1;
                  io_fault        <= 1'b1;
                  io_fault_domain <= idx;
                  state           <= FAULT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            GAP: begin
               if (cnt == CNT_ONE) begin
                  cnt <= '0;
                  if (idx == LAST_IDX) begin
                     io_done <= 1'b1;
                     state   <= RUN;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= RELEASE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            RUN: begin
               if (terminate_rise || io_soft_reset_req) begin
                  cnt             <= '0;
                  io_domain_reset <= '1;
                  io_done         <= 1'b0;
                  state           <= HOLD;
               end
            end

            FAULT: begin
               if (io_soft_reset_req) begin
                  cnt      <= '0;
                  io_fault <= 1'b0;
                  state    <= HOLD;
               end
            end

            default: begin
               cnt             <= '0;
               io_domain_reset <= '1;
               io_done         <= 1'b0;
               state           <= HOLD;
            end
         endcase
      end
   end

endmodule

// File: doc/reset_release_seq.md
RESET_RELEASE_SEQ -- requirements
Module: reset_release_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of reset-deassertion synchroniser flops (minimum 2).
REQ-002 SHALL have parameter NUM_DOMAINS, default 3, the number of downstream reset domains (minimum 1).
REQ-003 SHALL have parameter GAP_CYCLES, default 16, the number of hold cycles before the first release and between releases (minimum 1).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 1023, the maximum cycles to wait for a domain acknowledge (minimum 1).
REQ-005 SHALL have port clock  input  1  the single clock.
REQ-006 SHALL have port reset  input  1  the reset, which is asynchronous and active-low.
REQ-007 SHALL have port io_terminate  input  1  core restart request, acted on at its rising edge.
REQ-008 SHALL have port io_soft_reset_req  input  1  level restart request.
REQ-009 SHALL have port io_domain_ready  input  NUM_DOMAINS  bit i high means domain i has left reset.
REQ-010 SHALL have port io_domain_reset  output  NUM_DOMAINS  bit i is the active-high reset of domain i.
REQ-011 SHALL have port io_done  output  1  high when all domains are released.
REQ-012 SHALL have port io_fault  output  1  high when an acknowledge timeout has occurred.
REQ-013 SHALL have port io_fault_domain  output  max(1,clog2(NUM_DOMAINS))  index of the domain that timed out.

Function
REQ-014 SHALL implement the states HOLD, RELEASE, WAIT_ACK, GAP, RUN and FAULT.
REQ-015 SHALL hold all io_domain_reset bits high in HOLD, counting GAP_CYCLES cycles, then go to RELEASE with the domain index at 0.
REQ-016 SHALL, in RELEASE, clear io_domain_reset[idx] for one cycle, load the timeout counter and enter WAIT_ACK; a released bit stays low until the next HOLD or FAULT.
REQ-017 SHALL, in WAIT_ACK, go to GAP on the first cycle io_domain_ready[idx] is high, or to FAULT once ACK_TIMEOUT cycles have elapsed without it; ready arriving exactly on cycle ACK_TIMEOUT counts as success.
REQ-018 SHALL, in GAP, count GAP_CYCLES cycles, then go to RELEASE with idx+1, or to RUN if idx equals NUM_DOMAINS-1.
REQ-019 SHALL drive io_done high only in RUN.
REQ-020 SHALL, in RUN, go to HOLD with all resets reasserted on the next cycle when io_terminate rises or io_soft_reset_req is high; both events in the same cycle give a single restart.
REQ-021 SHALL ignore io_terminate and io_soft_reset_req in HOLD, RELEASE, WAIT_ACK and GAP, with no latching.
REQ-022 SHALL ignore a ready bit falling for an already-released domain.
REQ-023 SHALL, in FAULT, drive all io_domain_reset bits high and io_fault high, with io_fault_domain equal to the index that timed out.
REQ-024 SHALL leave FAULT only on io_soft_reset_req high, which clears io_fault and enters HOLD; io_terminate is ignored in FAULT.
REQ-025 SHALL size the counters to clog2(max(GAP_CYCLES, ACK_TIMEOUT)+1) bits, and no counter SHALL wrap.
REQ-026 SHALL detect the io_terminate edge using a registered copy that is cleared to 0 by reset.

Reset
REQ-027 SHALL, while reset is low, asynchronously force io_domain_reset to all-ones, io_done=0, io_fault=0, io_fault_domain=0, state=HOLD and counters=0.
REQ-028 SHALL synchronise reset deassertion through SYNC_STAGES flops, with assertion taking effect immediately.
REQ-029 SHALL begin the HOLD count on the first cycle the synchronised reset is released.
REQ-030 SHALL abort any state immediately when reset asserts mid-sequence, including RUN and FAULT.
REQ-031 SHALL, with default parameters, clear io_domain_reset[0] on rising edge SYNC_STAGES+GAP_CYCLES+1 counted from the first edge after reset rises.

Structure
REQ-032 SHALL take the state enum and the default parameter constants from the shared package reset_seq_pkg.
REQ-033 SHALL instantiate the sub-module reset_sync, a SYNC_STAGES-deep synchroniser with asynchronous assert and synchronous deassert, once.
REQ-034 SHALL place all sequencing in a single FSM with one shared down-counter, serving both the gap and timeout counts.

Verification (defaults: SYNC_STAGES=2, NUM_DOMAINS=3, GAP_CYCLES=16, ACK_TIMEOUT=1023)
REQ-035 SHALL verify: reset low for 5 cycles then high, each ready raised 3 cycles after its reset bit falls -> bit 0 falls on edge 19, bits 1 and 2 fall in order each separated by GAP, io_done=1, io_domain_reset=3'b000.
REQ-036 SHALL verify: ready[1] held low -> after 1023 cycles in WAIT_ACK, io_fault=1, io_fault_domain=1, io_domain_reset=3'b111, io_done=0.
REQ-037 SHALL verify: from FAULT, io_terminate pulsed -> no change; then io_soft_reset_req pulsed -> io_fault=0 and a full sequence completes with io_done=1.
REQ-038 SHALL verify: in RUN, io_terminate and io_soft_reset_req rise in the same cycle -> exactly one HOLD of 16 cycles, then the release of bit 0.
REQ-039 SHALL verify: reset pulsed low for 1 cycle during WAIT_ACK of domain 2 -> io_domain_reset=3'b111 immediately and the sequence restarts with the 2-cycle synchroniser delay.
REQ-040 SHALL verify: io_soft_reset_req asserted during GAP -> ignored, and io_done rises on schedule.
